mcu32x_wb_master: RTL and testbench
===================================

# mcu32x_wb_master

Single-outstanding Wishbone B4 classic-cycle initiator. It converts the MCU-32X core's valid/ready memory request port into bus cycles on the user-area Wishbone, so the core can reach external slaves, including the monitoring register slave. It captures read data, reports bus errors, and aborts cycles that no slave acknowledges within a bounded time.

## Interface
- `TIMEOUT`, default 255: cycles to wait for ack/err before abort; 0 disables the timeout.
- `wb_clk_i`  in  1  sole clock; all logic on its rising edge.
- `wb_rst_ni`  in  1  synchronous, active-low reset.
- `req_valid_i`  in  1  core request present.
- `req_ready_o`  out  1  block accepts a request this cycle.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  write data.
- `req_sel_i`  in  4  byte lane selects.
- `rsp_valid_o`  out  1  one-cycle response strobe; no backpressure.
- `rsp_rdata_o`  out  32  read data; 0 for writes, errors and timeouts.
- `rsp_err_o`  out  1  slave asserted `wbm_err_i`.
- `rsp_timeout_o`  out  1  cycle aborted by timeout.
- `busy_o`  out  1  state != IDLE.
- `wbm_cyc_o`, `wbm_stb_o`  out  1 each  Wishbone cycle and strobe; always equal.
- `wbm_we_o`  out  1  write enable.
- `wbm_sel_o`  out  4  byte selects.
- `wbm_adr_o`  out  32  address; bits [1:0] forced to 0.
- `wbm_dat_o`  out  32  write data.
- `wbm_dat_i`  in  32  read data.
- `wbm_ack_i`, `wbm_err_i`  in  1 each  slave termination.

## Operation
- **FSM states:** IDLE, BUS, RESP. All outputs are registered.
- **IDLE:**
  - `req_ready_o`=1.
  - When `req_valid_i`=1: latch we/addr/wdata/sel into the `wbm_*` registers, clear the timeout counter, go to BUS.
- **BUS:**
  - `wbm_cyc_o`=`wbm_stb_o`=1. `wbm_we_o`/`wbm_adr_o`/`wbm_sel_o`/`wbm_dat_o` are held stable for the whole cycle.
  - Ack: on `wbm_ack_i`=1, capture `wbm_dat_i` into `rsp_rdata_o` (reads only; writes load 0), deassert cyc/stb, go to RESP.
  - Error: on `wbm_err_i`=1, set `rsp_err_o`, load `rsp_rdata_o`=0, deassert cyc/stb, go to RESP. Err wins if ack and err are both high.
  - Timeout: the counter increments each BUS cycle without termination. When `TIMEOUT`!=0 and the counter reaches `TIMEOUT`-1 with no termination, set `rsp_timeout_o`, load data 0, deassert cyc/stb, go to RESP. An ack or err in that same cycle takes priority over the timeout.
- **RESP:**
  - `rsp_valid_o`=1 for exactly one cycle, then go to IDLE. `req_ready_o`=0.
  - `rsp_err_o`, `rsp_timeout_o` and `rsp_rdata_o` hold their values until the next response load.
- **Stray inputs:** `wbm_ack_i`/`wbm_err_i` seen in IDLE or RESP are ignored.
- **Counter:** 8-bit saturating. Values of `TIMEOUT` above 255 are clamped to 255.
- **Request port:** `req_*` inputs are sampled only when `req_valid_i && req_ready_o`. Requests presented while busy are held by the core, never dropped.
- **Reset:** `wb_rst_ni`=0 at a rising edge sets:
  - state = IDLE;
  - all `wbm_*` outputs = 0;
  - `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o` = 0;
  - `rsp_rdata_o` = 0;
  - `busy_o` = 0;
  - `req_ready_o` = 1 in the first cycle after reset release.
  
  A reset in the middle of a bus cycle drops cyc/stb at that edge and produces no response.

## Timing
- Request accepted at edge N → cyc/stb high from N+1.
- Zero-wait slave (ack sampled at edge N+2) → cyc low and `rsp_valid_o` high in cycle N+2..N+3.
- `req_ready_o` high again from edge N+3. Back-to-back throughput is therefore one transfer per 3 cycles.
- Each slave wait state adds 1 cycle.
- Timeout abort: cyc/stb high for exactly `TIMEOUT` cycles, then `rsp_valid_o` on the next cycle.
- cyc/stb never stay high in the cycle after termination is sampled. This gives no back-to-back strobe, which is classic-cycle compliant.

## Test plan
- **Zero-wait read.** Read at 0x3000_0004; slave acks on the first BUS cycle with 0xDEAD_BEEF. Required: `wbm_adr_o`=0x3000_0004, `wbm_we_o`=0; `rsp_valid_o` for 1 cycle with rdata 0xDEAD_BEEF and both error flags 0; total 3 cycles from accept to ready.
- **Write with waits.** Write 0x1234_5678 with sel 4'b0011 to 0x3000_000A; slave acks after 3 wait states. Required: `wbm_adr_o`=0x3000_0008; dat/sel stable for 4 BUS cycles; rsp rdata 0.
- **Error.** Read where the slave asserts ack and err in the same cycle. Required: `rsp_err_o`=1, rdata 0, `rsp_timeout_o`=0.
- **Timeout.** `TIMEOUT`=4, slave silent. Required: cyc high exactly 4 cycles; then `rsp_timeout_o`=1, rdata 0. Repeat with `TIMEOUT`=0 and a 300-cycle silence: cyc remains high and no response is issued.
- **Reset mid-cycle.** Assert `wb_rst_ni`=0 during BUS. Required: next edge all outputs 0, no `rsp_valid_o`; after release `req_ready_o`=1; a stray ack in IDLE has no effect.
- **Back-to-back.** Hold `req_valid_i` high with 3 queued reads. Required: 3 responses in order, each request accepted only while `req_ready_o`=1, no overlapping cyc cycles.

Source files
------------

// File: rtl/mcu32x_wb_master.sv
// Purpose : single-outstanding Wishbone B4 classic-cycle initiator bridging the MCU-32X valid/ready request port.
// Latency : accept -> cyc/stb next cycle; rsp_valid_o the cycle after ack/err/timeout; 3 cycles per zero-wait transfer.
// Backpress: req_ready_o drops from accept until the response strobe has passed; responses cannot be stalled.
//
// Ports:
//   wb_clk_i / wb_rst_ni          clock and synchronous active-low reset
//   req_valid_i / req_ready_o     core request handshake (we, addr, wdata, sel sampled on accept)
//   rsp_valid_o                   one-cycle response strobe with rsp_rdata_o / rsp_err_o / rsp_timeout_o
//   busy_o                        high whenever a transfer or its response is in progress
//   wbm_*                         Wishbone B4 classic master port (cyc == stb)
//
// TIMEOUT: cycles to wait for ack/err before aborting; 0 disables; values above 255 behave as 255.
module mcu32x_wb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sel_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The wait counter is only 8 bits wide, so larger limits saturate at 255.
    localparam int unsigned TO_CLAMP = (TIMEOUT > 255) ? 255 : TIMEOUT;
    localparam bit          TO_EN    = (TO_CLAMP != 0);
    // Abort fires in the BUS cycle whose count equals limit-1, giving exactly
    // TO_CLAMP cycles of cyc/stb before the response.
    localparam logic [7:0]  TO_LAST  = 8'((TO_CLAMP == 0) ? 0 : (TO_CLAMP - 1));

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_req_rdy;
    logic        r_busy;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_rsp_vld;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_to;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_req_rdy_nxt;
    logic        w_busy_nxt;
    logic        w_cyc_nxt;
    logic        w_we_nxt;
    logic [3:0]  w_sel_nxt;
    logic [31:0] w_adr_nxt;
    logic [31:0] w_dat_nxt;
    logic        w_rsp_vld_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic        w_rsp_err_nxt;
    logic        w_rsp_to_nxt;

    logic        w_accept;
    logic        w_to_hit;

    assign w_accept = req_valid_i && r_req_rdy;
    // Timeout only counts when neither termination is present this cycle.
    assign w_to_hit = TO_EN && (r_cnt == TO_LAST) && !wbm_ack_i && !wbm_err_i;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_rdy_nxt   = r_req_rdy;
        w_busy_nxt      = r_busy;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_rsp_vld_nxt   = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_to_nxt    = r_rsp_to;

        unique case (r_state)
            S_IDLE: begin
                w_req_rdy_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                w_cyc_nxt     = 1'b0;
                if (w_accept) begin
                    w_we_nxt      = req_we_i;
                    w_sel_nxt     = req_sel_i;
                    w_adr_nxt     = {req_addr_i[31:2], 2'b00};
                    w_dat_nxt     = req_wdata_i;
                    w_cnt_nxt     = 8'd0;
                    w_cyc_nxt     = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_req_rdy_nxt = 1'b0;
                    w_state_nxt   = S_BUS;
                end
            end

            S_BUS: begin
                w_req_rdy_nxt = 1'b0;
                w_busy_nxt    = 1'b1;
                if (wbm_err_i) begin
                    // err has priority over a simultaneous ack
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_vld_nxt   = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = S_RESP;
                end else if (wbm_ack_i) begin
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_rdata_nxt = r_we ? 32'd0 : wbm_dat_i;
                    w_rsp_vld_nxt   = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = S_RESP;
                end else if (w_to_hit) begin
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_to_nxt    = 1'b1;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_vld_nxt   = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_cyc_nxt = 1'b1;
                    if (r_cnt != 8'hFF) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            S_RESP: begin
                // The strobe lasts this single cycle; ready returns with IDLE.
                w_cyc_nxt     = 1'b0;
                w_busy_nxt    = 1'b0;
                w_req_rdy_nxt = 1'b1;
                w_state_nxt   = S_IDLE;
            end

            default: begin
                w_cyc_nxt     = 1'b0;
                w_busy_nxt    = 1'b0;
                w_req_rdy_nxt = 1'b1;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_req_rdy   <= 1'b1;
            r_busy      <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_rdy   <= w_req_rdy_nxt;
            r_busy      <= w_busy_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_rsp_vld   <= w_rsp_vld_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign req_ready_o   = r_req_rdy;
    assign busy_o        = r_busy;
    assign rsp_valid_o   = r_rsp_vld;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_to;
    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_cyc;
    assign wbm_we_o      = r_we;
    assign wbm_sel_o     = r_sel;
    assign wbm_adr_o     = r_adr;
    assign wbm_dat_o     = r_dat;

endmodule

// File: tb/tb_mcu32x_wb_master.sv
// Purpose : randomized and directed checks of mcu32x_wb_master against a transaction-level timing model.
// Latency : model predicts every output in every cycle from accept edge, slave wait count and TIMEOUT.
// Backpress: request driver holds req_valid_i and its payload until the handshake completes.
module tb_mcu32x_wb_master;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        req_ready, rsp_valid, rsp_err, rsp_to, busy;
    logic [31:0] rsp_rdata;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dato;
    logic [31:0] dati = '0;
    logic        ack = 1'b0, err = 1'b0;

    mcu32x_wb_master #(.TIMEOUT(T)) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rsp_timeout_o(rsp_to), .busy_o(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    // Auxiliary instances with a silent slave: timeout disabled, and limit above 255.
    logic        b_valid = 1'b0;
    logic        b_zero = 1'b0;
    logic [31:0] b_addr = 32'h4000_0010;
    logic [31:0] b_word = 32'd0;
    logic [3:0]  b_sel = 4'hF;
    logic        b0_ready, b0_rv, b0_err, b0_to, b0_busy, b0_cyc, b0_stb, b0_we;
    logic [31:0] b0_rd, b0_adr, b0_dat;
    logic [3:0]  b0_sel;
    logic        b1_ready, b1_rv, b1_err, b1_to, b1_busy, b1_cyc, b1_stb, b1_we;
    logic [31:0] b1_rd, b1_adr, b1_dat;
    logic [3:0]  b1_sel;

    mcu32x_wb_master #(.TIMEOUT(0)) u_dut_to0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b0_ready), .req_we_i(b_zero),
        .req_addr_i(b_addr), .req_wdata_i(b_word), .req_sel_i(b_sel),
        .rsp_valid_o(b0_rv), .rsp_rdata_o(b0_rd), .rsp_err_o(b0_err),
        .rsp_timeout_o(b0_to), .busy_o(b0_busy),
        .wbm_cyc_o(b0_cyc), .wbm_stb_o(b0_stb), .wbm_we_o(b0_we), .wbm_sel_o(b0_sel),
        .wbm_adr_o(b0_adr), .wbm_dat_o(b0_dat), .wbm_dat_i(b_word),
        .wbm_ack_i(b_zero), .wbm_err_i(b_zero)
    );

    mcu32x_wb_master #(.TIMEOUT(300)) u_dut_to300 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b1_ready), .req_we_i(b_zero),
        .req_addr_i(b_addr), .req_wdata_i(b_word), .req_sel_i(b_sel),
        .rsp_valid_o(b1_rv), .rsp_rdata_o(b1_rd), .rsp_err_o(b1_err),
        .rsp_timeout_o(b1_to), .busy_o(b1_busy),
        .wbm_cyc_o(b1_cyc), .wbm_stb_o(b1_stb), .wbm_we_o(b1_we), .wbm_sel_o(b1_sel),
        .wbm_adr_o(b1_adr), .wbm_dat_o(b1_dat), .wbm_dat_i(b_word),
        .wbm_ack_i(b_zero), .wbm_err_i(b_zero)
    );

    // kind: 0 ack, 1 err, 2 ack+err together, 3 silent; w = wait states before termination
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          kind;
        int          w;
        logic [31:0] rd;
    } req_t;

    int n_checks = 0;
    int n_err = 0;
    int edge_n = 0;

    req_t req_q[$];
    req_t plan_q[$];
    req_t cur;
    bit   have_req = 0;
    bit   rand_mode = 0;
    logic dut_ready_prev = 1'b0;

    // model
    bit          m_active = 0;
    int          m_n = 0, m_d = 0, m_res = 0;
    req_t        m_txn;
    logic        m_ready_prev = 1'b1;
    logic        m_we = 0;
    logic [31:0] m_adr = 0, m_dat = 0, m_rdata = 0;
    logic [3:0]  m_sel = 0;
    logic        m_err = 0, m_to = 0;

    // slave
    bit   s_prev_cyc = 0;
    bit   s_have = 0;
    int   s_idx = 0;
    req_t s_plan;
    bit   force_stray = 0;

    // observations for directed expectations
    int          o_acc_edge = -1, o_rdy_edge = -1, o_cyc_cnt = 0, o_rsp_cnt = 0;
    int          o_first_rsp = -1, o_last_rsp = -1;
    logic [31:0] o_adr = 0, o_rdata = 0;
    logic        o_err = 0, o_to = 0;
    logic [31:0] o_rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    function automatic req_t mk(input logic w_e, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int k, input int ws, input logic [31:0] rd);
        req_t r;
        r.we = w_e; r.addr = a; r.wdata = d; r.sel = s; r.kind = k; r.w = ws; r.rd = rd;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.sel   = 4'($urandom_range(0, 15));
        k       = $urandom_range(0, 19);
        r.kind  = (k < 10) ? 0 : (k < 13) ? 1 : (k < 16) ? 2 : 3;
        r.w     = $urandom_range(0, 6);
        r.rd    = $urandom;
        return r;
    endfunction

    // One clock: advance model, compare every output, then drive request and slave for next cycle.
    task automatic step();
        logic e_cyc, e_rdy, e_busy, e_rv;
        @(posedge clk);
        #1;
        edge_n++;

        // ---- model: what happened at this edge ----
        if (!rst_n) begin
            m_active = 0;
            m_we = 0; m_adr = 0; m_sel = 0; m_dat = 0;
            m_rdata = 0; m_err = 0; m_to = 0;
        end else if (m_ready_prev && req_valid) begin
            m_active = 1;
            m_n      = edge_n;
            m_txn    = cur;
            m_we     = req_we;
            m_adr    = {req_addr[31:2], 2'b00};
            m_sel    = req_sel;
            m_dat    = req_wdata;
            if (cur.kind != 3 && cur.w < T) begin
                m_d   = cur.w + 1;
                m_res = (cur.kind == 0) ? 0 : 1;
            end else begin
                m_d   = T;
                m_res = 2;
            end
        end

        e_cyc = 0; e_rv = 0; e_rdy = 1; e_busy = 0;
        if (m_active) begin
            if (edge_n < m_n + m_d) begin
                e_cyc = 1; e_rdy = 0; e_busy = 1;
            end else if (edge_n == m_n + m_d) begin
                e_rv = 1; e_rdy = 0; e_busy = 1;
                m_err   = (m_res == 1);
                m_to    = (m_res == 2);
                m_rdata = (m_res == 0 && !m_we) ? m_txn.rd : 32'd0;
            end else begin
                m_active = 0;
            end
        end
        m_ready_prev = e_rdy;

        // ---- compare ----
        chk("req_ready", req_ready, e_rdy);
        chk("busy", busy, e_busy);
        chk("cyc", cyc, e_cyc);
        chk("stb", stb, e_cyc);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("wbm_we", we, m_we);
        chk("wbm_adr", adr, m_adr);
        chk("wbm_sel", sel, m_sel);
        chk("wbm_dat", dato, m_dat);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_to, m_to);

        // ---- observations ----
        if (cyc) begin o_cyc_cnt++; o_adr = adr; end
        if (rsp_valid) begin
            o_rsp_cnt++; o_rdata = rsp_rdata; o_err = rsp_err; o_to = rsp_to;
            o_rsp_q.push_back(rsp_rdata);
            if (o_first_rsp < 0) o_first_rsp = edge_n;
            o_last_rsp = edge_n;
        end
        if (req_ready && o_rdy_edge < 0 && o_rsp_cnt > 0) o_rdy_edge = edge_n;

        // ---- request driver ----
        if (have_req && rst_n && req_valid && dut_ready_prev) begin
            plan_q.push_back(cur);
            have_req   = 0;
            o_acc_edge = edge_n;
        end
        if (!have_req) begin
            if (req_q.size() > 0) begin
                cur = req_q.pop_front(); have_req = 1;
            end else if (rand_mode && $urandom_range(0, 3) != 0) begin
                cur = rand_req(); have_req = 1;
            end
        end
        if (have_req) begin
            req_valid = 1; req_we = cur.we; req_addr = cur.addr;
            req_wdata = cur.wdata; req_sel = cur.sel;
        end else begin
            req_valid = 0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
            req_wdata = $urandom; req_sel = 4'($urandom_range(0, 15));
        end
        dut_ready_prev = req_ready;

        // ---- slave ----
        if (cyc) begin
            if (!s_prev_cyc) begin
                s_idx  = 0;
                s_have = (plan_q.size() > 0);
                if (s_have) s_plan = plan_q.pop_front();
            end else begin
                s_idx++;
            end
            ack  = s_have && (s_idx == s_plan.w) && (s_plan.kind == 0 || s_plan.kind == 2);
            err  = s_have && (s_idx == s_plan.w) && (s_plan.kind == 1 || s_plan.kind == 2);
            dati = ack ? s_plan.rd : $urandom;
        end else begin
            ack  = force_stray || ($urandom_range(0, 7) == 0);
            err  = force_stray ? 1'b0 : ($urandom_range(0, 9) == 0);
            dati = $urandom;
        end
        s_prev_cyc = cyc;
    endtask

    task automatic clear_obs();
        o_acc_edge = -1; o_rdy_edge = -1; o_cyc_cnt = 0; o_rsp_cnt = 0;
        o_first_rsp = -1; o_last_rsp = -1;
        o_rsp_q.delete();
    endtask

    task automatic run_one(input string nm, input req_t r, input int e_cyc, input logic [31:0] e_adr,
                           input logic [31:0] e_rd, input logic e_err, input logic e_to, input int e_period);
        clear_obs();
        req_q.push_back(r);
        for (int i = 0; i < 40 && o_rdy_edge < 0; i++) step();
        chk({nm, "_done"}, 32'(o_rdy_edge >= 0), 32'd1);
        chk({nm, "_cyc_cycles"}, o_cyc_cnt, e_cyc);
        chk({nm, "_adr"}, o_adr, e_adr);
        chk({nm, "_rsp_count"}, o_rsp_cnt, 32'd1);
        chk({nm, "_rdata"}, o_rdata, e_rd);
        chk({nm, "_err"}, o_err, e_err);
        chk({nm, "_timeout"}, o_to, e_to);
        chk({nm, "_period"}, o_rdy_edge + 1 - o_acc_edge, e_period);
    endtask

    initial begin
        int b0_cnt, b1_cnt, b1_rsp;
        logic b1_to_seen;

        // reset
        rst_n = 0;
        repeat (3) step();
        chk("reset_ready", req_ready, 32'd1);
        chk("reset_cyc", cyc, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        rst_n = 1;
        repeat (2) step();

        // directed transfers with hand-computed expectations
        run_one("zw_read", mk(0, 32'h3000_0004, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF),
                1, 32'h3000_0004, 32'hDEAD_BEEF, 0, 0, 3);
        run_one("wr_wait3", mk(1, 32'h3000_000A, 32'h1234_5678, 4'b0011, 0, 3, 32'hCAFE_F00D),
                4, 32'h3000_0008, 32'h0, 0, 0, 6);
        chk("wr_wait3_dat", dato, 32'h1234_5678);
        chk("wr_wait3_sel", sel, 32'h3);
        chk("wr_wait3_we", we, 32'd1);
        run_one("ack_err", mk(0, 32'h3000_0010, 32'h0, 4'hF, 2, 1, 32'h5555_AAAA),
                2, 32'h3000_0010, 32'h0, 1, 0, 4);
        run_one("timeout", mk(0, 32'h3000_0020, 32'h0, 4'hF, 3, 0, 32'h1111_2222),
                4, 32'h3000_0020, 32'h0, 0, 1, 6);
        run_one("ack_at_limit", mk(0, 32'h3000_0024, 32'h0, 4'hF, 0, 3, 32'h0BAD_CAFE),
                4, 32'h3000_0024, 32'h0BAD_CAFE, 0, 0, 6);

        // reset in the middle of a bus cycle
        clear_obs();
        req_q.push_back(mk(0, 32'h3000_0030, 32'h0, 4'hF, 3, 0, 32'h0));
        for (int i = 0; i < 10 && !cyc; i++) step();
        step();
        chk("midrst_cyc_before", cyc, 32'd1);
        rst_n = 0;
        step();
        chk("midrst_cyc", cyc, 32'd0);
        chk("midrst_rsp_valid", rsp_valid, 32'd0);
        chk("midrst_adr", adr, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        rst_n = 1;
        force_stray = 1;
        step();
        chk("midrst_ready", req_ready, 32'd1);
        repeat (5) step();
        force_stray = 0;
        chk("midrst_no_rsp", o_rsp_cnt, 32'd0);
        chk("stray_busy", busy, 32'd0);

        // back-to-back queued reads
        clear_obs();
        req_q.push_back(mk(0, 32'h3000_0040, 32'h0, 4'hF, 0, 0, 32'hA0A0_0001));
        req_q.push_back(mk(0, 32'h3000_0044, 32'h0, 4'hF, 0, 0, 32'hA0A0_0002));
        req_q.push_back(mk(0, 32'h3000_0048, 32'h0, 4'hF, 0, 0, 32'hA0A0_0003));
        for (int i = 0; i < 40 && o_rsp_cnt < 3; i++) step();
        chk("b2b_count", o_rsp_cnt, 32'd3);
        if (o_rsp_q.size() == 3) begin
            chk("b2b_rsp0", o_rsp_q[0], 32'hA0A0_0001);
            chk("b2b_rsp1", o_rsp_q[1], 32'hA0A0_0002);
            chk("b2b_rsp2", o_rsp_q[2], 32'hA0A0_0003);
        end
        chk("b2b_span", o_last_rsp - o_first_rsp, 32'd6);
        repeat (3) step();

        // randomized traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        repeat (20) step();

        // silent slave: timeout disabled vs. limit clamped to 255
        b0_cnt = 0; b1_cnt = 0; b1_rsp = 0; b1_to_seen = 0;
        b_valid = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) b_valid = 0;
            if (b0_cyc) b0_cnt++;
            if (b1_cyc) b1_cnt++;
            if (b1_rv) begin b1_rsp++; b1_to_seen = b1_to; end
            if (b0_rv) begin
                n_checks++; n_err++;
                $display("FAIL to0_rsp_valid @edge %0d: got 1 expected 0", edge_n);
            end
        end
        chk("to0_cyc_cycles", b0_cnt, 32'd300);
        chk("to0_cyc_still_high", b0_cyc, 32'd1);
        chk("to0_busy", b0_busy, 32'd1);
        chk("to300_cyc_cycles", b1_cnt, 32'd255);
        chk("to300_rsp_count", b1_rsp, 32'd1);
        chk("to300_timeout", b1_to_seen, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

endmodule
